// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared encodings for the multi-product vending controller
// Holds the FSM state type, inserted-coin codes with their values, and the
// change-coin codes driven on chg_coin.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_e;

  // Inserted coin codes (coin input)
  localparam logic [1:0] COIN_4   = 2'b00;
  localparam logic [1:0] COIN_3   = 2'b11;
  localparam logic [1:0] COIN_2   = 2'b10;
  localparam logic [1:0] COIN_INV = 2'b01;

  // Returned change coin codes (chg_coin output)
  localparam logic [1:0] CHG_4 = 2'b00;
  localparam logic [1:0] CHG_3 = 2'b11;
  localparam logic [1:0] CHG_2 = 2'b10;
  localparam logic [1:0] CHG_1 = 2'b01;

  // Credit value of an inserted coin; the invalid code is worth nothing.
  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_4:  return 3'd4;
      COIN_3:  return 3'd3;
      COIN_2:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// rtl/vend_change_sel.sv - greedy change-coin picker
// Ports:
//   credit  in   CW  remaining credit to be returned
//   d       out  3   largest denomination in {4,3,2,1} not above credit (0 if credit is 0)
//   code    out  2   chg_coin encoding of d
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int CW = 5
) (
  input  logic [CW-1:0] credit,
  output logic [2:0]    d,
  output logic [1:0]    code
);

  always_comb begin
    d    = 3'd0;
    code = CHG_4;
    if (credit >= CW'(4)) begin
      d    = 3'd4;
      code = CHG_4;
    end else if (credit == CW'(3)) begin
      d    = 3'd3;
      code = CHG_3;
    end else if (credit == CW'(2)) begin
      d    = 3'd2;
      code = CHG_2;
    end else if (credit == CW'(1)) begin
      d    = 3'd1;
      code = CHG_1;
    end
  end

endmodule

// File: rtl/vend_fsm_multi.sv
// rtl/vend_fsm_multi.sv - multi-product vending controller with greedy change return
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-low reset
//   coin_valid, coin          coin strobe and code from the acceptor
//   sel_valid, sel            product selection strobe and 1-based index
//   cancel                    refund request
//   prod_valid, prod_out      one-cycle vend pulse and product index
//   chg_valid, chg_coin       one-cycle change-coin pulse and coin code
//   credit                    current credit
//   busy                      high while vending or returning change
//   coin_reject, err          one-cycle pulses: coin refused, selection refused
module vend_fsm_multi
  import vend_pkg::*;
#(
  parameter int                         NUM_PROD   = 4,
  parameter int                         CW         = 5,
  parameter int                         MAX_CREDIT = 31,
  parameter logic [NUM_PROD*CW-1:0]     PRICES     = {5'd12, 5'd9, 5'd7, 5'd4},
  localparam int                        SEL_W      = $clog2(NUM_PROD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_valid,
  input  logic [1:0]       coin,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  input  logic             cancel,
  output logic             prod_valid,
  output logic [SEL_W-1:0] prod_out,
  output logic             chg_valid,
  output logic [1:0]       chg_coin,
  output logic [CW-1:0]    credit,
  output logic             busy,
  output logic             coin_reject,
  output logic             err
);

  state_e           state_q, state_d;
  logic [CW-1:0]    credit_q, credit_d;
  logic             prod_valid_q, prod_valid_d;
  logic [SEL_W-1:0] prod_out_q, prod_out_d;
  logic             chg_valid_q, chg_valid_d;
  logic [1:0]       chg_coin_q, chg_coin_d;
  logic             coin_reject_q, coin_reject_d;
  logic             err_q, err_d;

  logic [CW:0]      coin_sum;
  logic [CW:0]      cand;
  logic             coin_bad;
  logic [CW-1:0]    price;
  logic             sel_ok;
  logic [2:0]       chg_d;
  logic [1:0]       chg_code;

  vend_change_sel #(.CW(CW)) u_change_sel (
    .credit (credit_q),
    .d      (chg_d),
    .code   (chg_code)
  );

  // Candidate credit is one bit wider so overflow past MAX_CREDIT is visible.
  always_comb begin
    coin_sum = {1'b0, credit_q} + (CW+1)'(coin_value(coin));
    coin_bad = coin_valid && ((coin == COIN_INV) || (coin_sum > (CW+1)'(MAX_CREDIT)));
    cand     = (coin_valid && !coin_bad) ? coin_sum : {1'b0, credit_q};
  end

  // Price lookup; out-of-range selections (including 0) leave sel_ok low.
  always_comb begin
    price  = '0;
    sel_ok = 1'b0;
    for (int k = 1; k <= NUM_PROD; k++) begin
      if (sel == SEL_W'(k)) begin
        price  = PRICES[k*CW-1 -: CW];
        sel_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    prod_valid_d  = 1'b0;
    prod_out_d    = '0;
    chg_valid_d   = 1'b0;
    chg_coin_d    = CHG_4;
    coin_reject_d = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        coin_reject_d = coin_bad;
        if (cancel) begin
          // A same-cycle coin is refunded too; nothing to return means no-op.
          if (cand != '0) begin
            credit_d = cand[CW-1:0];
            state_d  = ST_CHANGE;
          end
        end else if (sel_valid) begin
          if (sel_ok && (cand >= {1'b0, price})) begin
            credit_d     = CW'(cand - {1'b0, price});
            prod_valid_d = 1'b1;
            prod_out_d   = sel;
            state_d      = ST_VEND;
          end else begin
            credit_d = cand[CW-1:0];
            err_d    = 1'b1;
          end
        end else begin
          credit_d = cand[CW-1:0];
        end
      end

      ST_VEND: begin
        coin_reject_d = coin_valid;
        state_d       = (credit_q != '0) ? ST_CHANGE : ST_ACCUM;
      end

      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        chg_valid_d   = 1'b1;
        chg_coin_d    = chg_code;
        credit_d      = credit_q - CW'(chg_d);
        if (credit_q == CW'(chg_d)) begin
          state_d = ST_ACCUM;
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_ACCUM;
      credit_q      <= '0;
      prod_valid_q  <= 1'b0;
      prod_out_q    <= '0;
      chg_valid_q   <= 1'b0;
      chg_coin_q    <= 2'b00;
      coin_reject_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      prod_valid_q  <= prod_valid_d;
      prod_out_q    <= prod_out_d;
      chg_valid_q   <= chg_valid_d;
      chg_coin_q    <= chg_coin_d;
      coin_reject_q <= coin_reject_d;
      err_q         <= err_d;
    end
  end

  assign prod_valid  = prod_valid_q;
  assign prod_out    = prod_out_q;
  assign chg_valid   = chg_valid_q;
  assign chg_coin    = chg_coin_q;
  assign credit      = credit_q;
  assign busy        = (state_q != ST_ACCUM);
  assign coin_reject = coin_reject_q;
  assign err         = err_q;

endmodule

// File: tb/tb_vend_fsm_multi.sv
// tb/tb_vend_fsm_multi.sv - scoreboard testbench for vend_fsm_multi
module tb_vend_fsm_multi;

  localparam int K_PROD = 0;
  localparam int K_CHG  = 1;
  localparam int K_REJ  = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       sel_valid = 1'b0;
  logic [2:0] sel = 3'd0;
  logic       cancel = 1'b0;
  logic       prod_valid;
  logic [2:0] prod_out;
  logic       chg_valid;
  logic [1:0] chg_coin;
  logic [4:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       err;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  n;
  ev_t exp_q[$];

  vend_fsm_multi dut (
    .clk         (clk),
    .rst         (rst),
    .coin_valid  (coin_valid),
    .coin        (coin),
    .sel_valid   (sel_valid),
    .sel         (sel),
    .cancel      (cancel),
    .prod_valid  (prod_valid),
    .prod_out    (prod_out),
    .chg_valid   (chg_valid),
    .chg_coin    (chg_coin),
    .credit      (credit),
    .busy        (busy),
    .coin_reject (coin_reject),
    .err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_ev(input int k, input int v, input int c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic got(input int k, input int v);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_pulse: kind %0d val %0d at cycle %0d, none expected", k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL pulse: got kind %0d val %0d cycle %0d expected kind %0d val %0d cycle %0d",
                 k, v, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: consumes expected pulses in time order, same-cycle order prod, chg, rej, err.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missed_pulse: kind %0d val %0d due cycle %0d, now cycle %0d",
               exp_q[0].kind, exp_q[0].val, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (prod_valid)  got(K_PROD, int'(prod_out));
    if (chg_valid)   got(K_CHG, int'(chg_coin));
    if (coin_reject) got(K_REJ, 0);
    if (err)         got(K_ERR, 0);
  end

  task automatic step(input logic cv, input logic [1:0] c, input logic sv,
                      input logic [2:0] s, input logic cn);
    coin_valid = cv;
    coin       = c;
    sel_valid  = sv;
    sel        = s;
    cancel     = cn;
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    coin       = 2'b00;
    sel_valid  = 1'b0;
    sel        = 3'd0;
    cancel     = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) step(1'b0, 2'b00, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic ins(input logic [1:0] c);
    step(1'b1, c, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    idle(2);
    check("reset_outputs", int'({prod_valid, prod_out, chg_valid, chg_coin, coin_reject, err, busy}), 0);
    check("reset_credit", int'(credit), 0);
    rst = 1'b1;
    idle(1);

    // 8 credit, product 2 (price 7): vend then one 1-coin
    ins(2'b00); ins(2'b00);
    check("credit_8", int'(credit), 8);
    n = cyc;
    push_ev(K_PROD, 2, n + 1);
    push_ev(K_CHG, 1, n + 3);
    step(1'b0, 2'b00, 1'b1, 3'd2, 1'b0);
    check("busy_in_vend", int'(busy), 1);
    idle(4);
    check("credit_after_p2", int'(credit), 0);
    check("idle_after_p2", int'(busy), 0);

    // 12 credit, product 3 (price 9): change 3
    ins(2'b00); ins(2'b00); ins(2'b00);
    n = cyc;
    push_ev(K_PROD, 3, n + 1);
    push_ev(K_CHG, 3, n + 3);
    step(1'b0, 2'b00, 1'b1, 3'd3, 1'b0);
    idle(4);
    check("credit_after_p3", int'(credit), 0);

    // 12 credit, product 4 (price 12): no change; coin during VEND rejected
    ins(2'b00); ins(2'b00); ins(2'b00);
    n = cyc;
    push_ev(K_PROD, 4, n + 1);
    push_ev(K_REJ, 0, n + 2);
    step(1'b0, 2'b00, 1'b1, 3'd4, 1'b0);
    ins(2'b00);
    idle(3);
    check("credit_after_p4", int'(credit), 0);

    // 10 credit, cancel: 4,4,2; coin during CHANGE rejected
    ins(2'b00); ins(2'b00); ins(2'b10);
    n = cyc;
    push_ev(K_CHG, 0, n + 2);
    push_ev(K_REJ, 0, n + 2);
    push_ev(K_CHG, 0, n + 3);
    push_ev(K_CHG, 2, n + 4);
    step(1'b0, 2'b00, 1'b0, 3'd0, 1'b1);
    ins(2'b00);
    idle(5);
    check("credit_after_refund10", int'(credit), 0);

    // Refused selections and invalid coin at credit 3
    ins(2'b11);
    n = cyc; push_ev(K_ERR, 0, n + 1);
    step(1'b0, 2'b00, 1'b1, 3'd1, 1'b0);
    check("credit_after_err_p1", int'(credit), 3);
    n = cyc; push_ev(K_ERR, 0, n + 1);
    step(1'b0, 2'b00, 1'b1, 3'd0, 1'b0);
    n = cyc; push_ev(K_REJ, 0, n + 1);
    ins(2'b01);
    check("credit_after_bad_coin", int'(credit), 3);
    n = cyc; push_ev(K_ERR, 0, n + 1);
    step(1'b0, 2'b00, 1'b1, 3'd5, 1'b0);
    n = cyc; push_ev(K_CHG, 3, n + 2);
    step(1'b0, 2'b00, 1'b0, 3'd0, 1'b1);
    idle(3);
    check("credit_after_refund3", int'(credit), 0);
    step(1'b0, 2'b00, 1'b0, 3'd0, 1'b1);
    check("cancel_at_zero_stays", int'(busy), 0);
    idle(2);

    // Saturation: 28 + 2 = 30, then 30 + 3 refused; refund 30
    repeat (7) ins(2'b00);
    ins(2'b10);
    check("credit_30", int'(credit), 30);
    n = cyc; push_ev(K_REJ, 0, n + 1);
    ins(2'b11);
    check("credit_30_after_reject", int'(credit), 30);
    n = cyc;
    for (int i = 0; i < 7; i++) push_ev(K_CHG, 0, n + 2 + i);
    push_ev(K_CHG, 2, n + 9);
    step(1'b0, 2'b00, 1'b0, 3'd0, 1'b1);
    idle(10);
    check("credit_after_refund30", int'(credit), 0);

    // 29 + 3 refused, 29 + 2 = 31 (ceiling), 31 + 2 refused; refund 31 in 8 coins
    repeat (5) ins(2'b00);
    repeat (3) ins(2'b11);
    check("credit_29", int'(credit), 29);
    n = cyc; push_ev(K_REJ, 0, n + 1);
    ins(2'b11);
    check("credit_29_after_reject", int'(credit), 29);
    ins(2'b10);
    check("credit_31", int'(credit), 31);
    n = cyc; push_ev(K_REJ, 0, n + 1);
    ins(2'b10);
    check("credit_31_after_reject", int'(credit), 31);
    n = cyc;
    for (int i = 0; i < 7; i++) push_ev(K_CHG, 0, n + 2 + i);
    push_ev(K_CHG, 3, n + 9);
    step(1'b0, 2'b00, 1'b0, 3'd0, 1'b1);
    idle(10);
    check("credit_after_refund31", int'(credit), 0);

    // Same-cycle coin + selection: 2 + 2 = 4 buys product 1
    ins(2'b10);
    n = cyc; push_ev(K_PROD, 1, n + 1);
    step(1'b1, 2'b10, 1'b1, 3'd1, 1'b0);
    check("credit_same_cycle_vend", int'(credit), 0);
    idle(3);
    check("idle_after_same_cycle", int'(busy), 0);

    // Reset during the second change pulse of a 10-credit refund
    ins(2'b00); ins(2'b00); ins(2'b10);
    n = cyc;
    push_ev(K_CHG, 0, n + 2);
    push_ev(K_CHG, 0, n + 3);
    step(1'b0, 2'b00, 1'b0, 3'd0, 1'b1);
    idle(2);
    check("credit_mid_refund", int'(credit), 2);
    rst = 1'b0;
    idle(1);
    check("reset_mid_outputs", int'({prod_valid, prod_out, chg_valid, chg_coin, coin_reject, err, busy}), 0);
    check("reset_mid_credit", int'(credit), 0);
    rst = 1'b1;
    idle(6);
    check("credit_after_abandon", int'(credit), 0);
    check("busy_after_abandon", int'(busy), 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
